divide_8_bit_seq: RTL

Iterative unsigned restoring divider, the inverse operation of multiply_8_bit in the arithmetic TP set. Computes quotient and remainder of x / y, one quotient bit per clock, under a start/done handshake. Sits beside the combinational multiplier so benches can check the round trip: multiply, then divide back.

---
 rtl/divide_8_bit_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/divide_8_bit_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Optional build macro DIV_ZERO_TRAP_EN short-circuits a zero divisor straight to DONE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | WIDTH shift/subtract iterations on the captured operands
// DONE  | last iteration finished; results latch and done pulses next
module divide_8_bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             trap;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

`ifdef DIV_ZERO_TRAP_EN
    assign trap = (y == '0);
`else
    assign trap = 1'b0;
`endif

    // trial is computed one bit wider so its MSB is the borrow
    always_comb begin
        rem_sh = {rem, dvd[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr};
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                accept = start;
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                accept    = start;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (accept) begin
            state_nxt = trap ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            dvd <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (accept) begin
            rem <= '0;
            dvd <= trap ? '0 : x;
            dsr <= y;
            cnt <= CW'(WIDTH - 1);
        end else if (state == S_RUN) begin
            dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
            rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt <= cnt - CW'(1);
        end
    end

    // results become visible together with the done pulse, one edge after DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_DONE) begin
                done        <= 1'b1;
                q           <= dvd;
                r           <= rem;
                div_by_zero <= (dsr == '0);
            end
        end
    end

    assign busy = (state == S_RUN);

endmodule
